// File: rtl/mdu_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mdu_sched
// Purpose  : Multi-cycle multiply/divide scheduler for the execute stage.
//            Latches MD operands from E, computes the result into shadow
//            registers, runs a fixed-latency busy countdown and then commits
//            HI/LO with a one-cycle done pulse. Requests a pipeline stall
//            when an MD-class instruction in decode would collide with it.
// Revision : 1.0  initial release
// ============================================================================
module mdu_sched #(
  parameter int MUL_CYCLES = 5,   // busy cycles for mult/multu
  parameter int DIV_CYCLES = 10,  // busy cycles for div/divu
  parameter int CNT_W      = 4    // countdown width
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done,
  output logic        md_stall
);

  // Operation encodings carried on op
  localparam logic [2:0] c_OP_MULT  = 3'b000;
  localparam logic [2:0] c_OP_MULTU = 3'b001;
  localparam logic [2:0] c_OP_DIV   = 3'b010;
  localparam logic [2:0] c_OP_DIVU  = 3'b011;
  localparam logic [2:0] c_OP_MTHI  = 3'b100;
  localparam logic [2:0] c_OP_MTLO  = 3'b101;

  localparam logic [CNT_W-1:0] c_MUL_LAT = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] c_DIV_LAT = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      res_hi_q;   // shadow result, committed at end of countdown
  logic [31:0]      res_lo_q;
  logic             res_wr_q;   // cleared for divide-by-zero so HI/LO survive

  // Next values for the shadow result registers, computed from E operands
  logic [31:0]      res_hi_d;
  logic [31:0]      res_lo_d;
  logic             res_wr_d;
  logic [CNT_W-1:0] lat_d;
  logic             is_arith;
  logic             is_div;

  // Multiplier datapath
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;

  // Divider datapath: signed divide is done on magnitudes, then re-signed
  logic        div_signed;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] dvs_safe;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign is_arith = (op == c_OP_MULT) || (op == c_OP_MULTU) ||
                    (op == c_OP_DIV)  || (op == c_OP_DIVU);
  assign is_div   = (op == c_OP_DIV)  || (op == c_OP_DIVU);

  assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) *
                  $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  assign div_signed = (op == c_OP_DIV);
  assign dvd_mag    = (div_signed && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
  assign dvs_mag    = (div_signed && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;
  // A zero divisor is replaced so the divider never sees it; the result is
  // discarded anyway via res_wr_d.
  assign dvs_safe   = (dvs_mag == 32'd0) ? 32'd1 : dvs_mag;
  assign quo_mag    = dvd_mag / dvs_safe;
  assign rem_mag    = dvd_mag % dvs_safe;
  // Quotient truncates toward zero; remainder follows the dividend sign.
  assign quo_fix    = (div_signed && (rs_val[31] ^ rt_val[31])) ?
                      (~quo_mag + 32'd1) : quo_mag;
  assign rem_fix    = (div_signed && rs_val[31]) ? (~rem_mag + 32'd1) : rem_mag;

  // Select result, commit enable and latency for the issuing operation
  always_comb begin
    res_hi_d = 32'd0;
    res_lo_d = 32'd0;
    res_wr_d = 1'b1;
    lat_d    = c_MUL_LAT;
    case (op)
      c_OP_MULT: begin
        res_hi_d = prod_s[63:32];
        res_lo_d = prod_s[31:0];
      end
      c_OP_MULTU: begin
        res_hi_d = prod_u[63:32];
        res_lo_d = prod_u[31:0];
      end
      c_OP_DIV, c_OP_DIVU: begin
        res_hi_d = rem_fix;
        res_lo_d = quo_fix;
        res_wr_d = (rt_val != 32'd0);
        lat_d    = c_DIV_LAT;
      end
      default: begin
        res_hi_d = 32'd0;
        res_lo_d = 32'd0;
      end
    endcase
  end

  // Scheduler FSM: issue, countdown, commit; all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      res_wr_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (is_arith) begin
              res_hi_q <= res_hi_d;
              res_lo_q <= res_lo_d;
              res_wr_q <= res_wr_d;
              cnt_q    <= lat_d;
              busy_q   <= 1'b1;
              state_q  <= S_BUSY;
            end else if (op == c_OP_MTHI) begin
              hi_q <= rs_val;
            end else if (op == c_OP_MTLO) begin
              lo_q <= rs_val;
            end
          end
        end
        S_BUSY: begin
          // New starts are ignored here; the hazard unit keeps them away.
          if (cnt_q == c_CNT_ONE) begin
            if (res_wr_q) begin
              hi_q <= res_hi_q;
              lo_q <= res_lo_q;
            end
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - c_CNT_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  // Stall D while busy or while an arithmetic MD op is issuing; gated by
  // reset so a start held during reset cannot leak a stall.
  assign md_stall = ~reset & d_is_md & (busy_q | (start & is_arith));

  // is_div is kept for readability of the latency select; fold it in here
  // so it is consumed.
  logic unused_ok;
  assign unused_ok = is_div;

endmodule
`default_nettype wire

// File: tb/tb_mdu_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mdu_sched
// Purpose  : Directed self-checking bench for mdu_sched with a result
//            scoreboard (expected HI/LO pushed at issue, popped at commit).
// Revision : 1.0  initial release
// ============================================================================
module tb_mdu_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_is_md;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;
  logic        md_stall;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] sb_q[$];

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  always #5 clk = ~clk;

  mdu_sched #(
    .MUL_CYCLES(MUL_N),
    .DIV_CYCLES(DIV_N),
    .CNT_W     (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .d_is_md (d_is_md),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .done    (done),
    .md_stall(md_stall)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one arithmetic op in the current low phase and follow it to commit.
  // Returns in the low phase of the commit cycle (t+N+1).
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic dmd,
                        input logic [31:0] ehi, input logic [31:0] elo, input bit inject);
    logic [63:0] e;
    sb_q.push_back({ehi, elo});
    start = 1'b1; op = o; rs_val = a; rt_val = b; d_is_md = dmd;
    #1 chk({tag, " stall_issue"}, 64'(md_stall), 64'(dmd));
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (inject && k == 3) begin
        start = 1'b1; op = 3'b001; rs_val = 32'd5; rt_val = 32'd7;
      end
      if (inject && k == 6) begin
        start = 1'b1; op = 3'b100; rs_val = 32'hDEADBEEF;
      end
      #1;
      chk($sformatf("%s busy_c%0d", tag, k), 64'(busy), 64'(1));
      chk($sformatf("%s done_c%0d", tag, k), 64'(done), 64'(0));
      chk($sformatf("%s stall_c%0d", tag, k), 64'(md_stall), 64'(dmd));
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    chk({tag, " busy_end"}, 64'(busy), 64'(0));
    chk({tag, " done_pulse"}, 64'(done), 64'(1));
    chk({tag, " stall_end"}, 64'(md_stall), 64'(0));
    e = sb_q.pop_front();
    chk({tag, " hi"}, 64'(hi), 64'(e[63:32]));
    chk({tag, " lo"}, 64'(lo), 64'(e[31:0]));
  endtask

  // Quiet cycles: nothing in flight, HI/LO hold.
  task automatic idle_chk(input string tag, input int n, input logic [31:0] ehi,
                          input logic [31:0] elo);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("%s busy_i%0d", tag, k), 64'(busy), 64'(0));
      chk($sformatf("%s done_i%0d", tag, k), 64'(done), 64'(0));
      chk($sformatf("%s stall_i%0d", tag, k), 64'(md_stall), 64'(0));
      chk($sformatf("%s hi_i%0d", tag, k), 64'(hi), 64'(ehi));
      chk($sformatf("%s lo_i%0d", tag, k), 64'(lo), 64'(elo));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; op = 3'b000; rs_val = 32'd0; rt_val = 32'd0; d_is_md = 1'b1;
    #1;
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    chk("rst hi", 64'(hi), 64'(0));
    chk("rst lo", 64'(lo), 64'(0));
    chk("rst stall_gated", 64'(md_stall), 64'(0));
    start = 1'b0; d_is_md = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Multiply: signed and unsigned, with and without a D-stage MD op
    run_op("mult", 3'b000, 32'hFFFFFFFF, 32'h2, MUL_N, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    idle_chk("post_mult", 1, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu", 3'b001, 32'hFFFFFFFF, 32'h2, MUL_N, 1'b0, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    idle_chk("post_multu", 1, 32'h00000001, 32'hFFFFFFFE);

    // Divide, then back-to-back issues in the commit cycle
    run_op("div_neg", 3'b010, 32'hFFFFFFF9, 32'h2, DIV_N, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("divu", 3'b011, 32'h7, 32'h2, DIV_N, 1'b1, 32'h1, 32'h3, 1'b0);
    run_op("div_negdvs", 3'b010, 32'h7, 32'hFFFFFFFE, DIV_N, 1'b0, 32'h1, 32'hFFFFFFFD, 1'b0);
    run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_N, 1'b1, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    idle_chk("post_b2b", 1, 32'hFFFFFFFE, 32'h00000001);

    // mthi / mtlo: immediate, no busy, no stall
    start = 1'b1; op = 3'b100; rs_val = 32'h12345678; d_is_md = 1'b1;
    #1 chk("mthi stall", 64'(md_stall), 64'(0));
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("mthi hi", 64'(hi), 64'h12345678);
    chk("mthi lo", 64'(lo), 64'h00000001);
    chk("mthi busy", 64'(busy), 64'(0));
    start = 1'b1; op = 3'b101; rs_val = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("mtlo lo", 64'(lo), 64'h9ABCDEF0);
    chk("mtlo hi", 64'(hi), 64'h12345678);
    chk("mtlo done", 64'(done), 64'(0));

    // Reserved opcodes leave everything alone
    start = 1'b1; op = 3'b110; rs_val = 32'h55555555; d_is_md = 1'b0;
    @(negedge clk);
    op = 3'b111;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("rsvd busy", 64'(busy), 64'(0));
    idle_chk("rsvd", 2, 32'h12345678, 32'h9ABCDEF0);

    // Divide by zero: full latency and done, HI/LO unchanged
    run_op("div0", 3'b010, 32'h00001234, 32'h0, DIV_N, 1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    run_op("divu0", 3'b011, 32'hFFFFFFFF, 32'h0, DIV_N, 1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    idle_chk("post_div0", 1, 32'h12345678, 32'h9ABCDEF0);

    // Starts during a divide (multu, mthi) are ignored
    run_op("div_inj", 3'b010, 32'd100, 32'd7, DIV_N, 1'b1, 32'd2, 32'd14, 1'b1);
    idle_chk("post_inj", 2, 32'd2, 32'd14);

    // Async reset in busy cycle 3 of a mult discards the result
    start = 1'b1; op = 3'b000; rs_val = 32'd3; rt_val = 32'd4; d_is_md = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1 chk("rstmid pre_busy", 64'(busy), 64'(1));
    start = 1'b1; op = 3'b000;
    reset = 1'b1;
    #1;
    chk("rstmid busy", 64'(busy), 64'(0));
    chk("rstmid done", 64'(done), 64'(0));
    chk("rstmid hi", 64'(hi), 64'(0));
    chk("rstmid lo", 64'(lo), 64'(0));
    chk("rstmid stall", 64'(md_stall), 64'(0));
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    idle_chk("post_rst", 10, 32'd0, 32'd0);

    chk("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
- Multi-cycle multiply/divide scheduler for the E stage of the 5-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo issued from E and latches operands so E can advance.
- Runs a fixed-latency busy countdown, commits HI/LO on completion, and drives a stall request to the hazard unit when an MD-class instruction sits in D while the unit is occupied.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (must be >=1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >=1).
- CNT_W, 4, countdown width; must hold max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  E-stage MD instruction valid this cycle.
- op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 reserved.
- rs_val  input  32  forwarded E-stage rs operand (dividend / multiplicand / mthi-mtlo source).
- rt_val  input  32  forwarded E-stage rt operand (divisor / multiplier).
- d_is_md  input  1  D-stage instruction is MD-class (mult*, div*, mfhi, mflo, mthi, mtlo).
- busy  output  1  operation in flight.
- hi  output  32  committed HI register.
- lo  output  32  committed LO register.
- done  output  1  one-cycle pulse; HI/LO just committed.
- md_stall  output  1  stall request to the hazard unit; combinational.

Behaviour:
- Reset (async, any cycle, including mid-operation): state=IDLE, counter=0, busy=0, done=0, hi=lo=0. Any in-flight result is discarded.
- States are IDLE and BUSY.
- IDLE, start=1, op in {000..011}, sampled at the edge ending cycle t:
  - Latch operands and compute the result into shadow registers res_hi/res_lo.
  - Load counter with N (MUL_CYCLES or DIV_CYCLES); go to BUSY.
  - busy=1 for exactly cycles t+1 .. t+N.
- BUSY: counter decrements each edge. At the edge ending cycle t+N: hi<=res_hi, lo<=res_lo, busy<=0, done<=1, state returns to IDLE. New hi/lo values and done=1 appear together in cycle t+N+1; done is 0 in cycle t+N+2.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi = [63:32], lo = [31:0].
  - multu: unsigned 32x32 -> 64, same split.
  - div: signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient in lo, remainder in hi.
- Divide by zero (rt_val=0, div or divu): full DIV_CYCLES busy and done pulse still occur; hi/lo keep their prior values.
- mthi/mtlo (start=1 in IDLE): hi (resp. lo) <= rs_val at that edge. No busy, no done.
- Reserved ops (110/111): ignored; no state change.
- Any start while BUSY (any op): ignored; the in-flight result is unaffected. The hazard unit prevents this case; the behaviour is defined here for verification.
- md_stall = d_is_md & (busy | (start & op in {000..011})). It is 0 whenever reset=1.
- Back-to-back issue: start is accepted in cycle t+N+1, the first cycle after busy falls.
- Reads of hi/lo while busy return the old committed values; mfhi/mflo are stalled by md_stall upstream.

Test Plan:
- mult rs=0xFFFFFFFF, rt=0x00000002 -> busy in exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE with done=1 for 1 cycle. Same operands with multu -> hi=0x00000001, lo=0xFFFFFFFE.
- div rs=0xFFFFFFF9 (-7), rt=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu rs=7, rt=2 -> lo=3, hi=1.
- mthi 0x12345678, mtlo 0x9ABCDEF0, then div rt=0 -> busy 10 cycles, done pulses, hi=0x12345678, lo=0x9ABCDEF0 unchanged.
- Stall timing:
  - d_is_md=1 in the start cycle of a mult -> md_stall=1 in that cycle and throughout cycles t+1..t+5.
  - md_stall=0 in cycle t+6.
  - d_is_md=0 -> md_stall=0 throughout.
- During a div in flight, pulse start with op=multu and with op=mthi (rs=0xDEADBEEF) -> both ignored; the final hi/lo equal the div result.
- Reset asserted asynchronously in busy cycle 3 of a mult -> busy, done, hi and lo are all 0 immediately, before the next edge. After release, no commit or done pulse occurs.
